inst_fetch: RTL

//   IF stage of the 5-stage MIPS pipeline; the producer of the {pc_plus4, inst} pair that the decode stage consumes.

---
 rtl/inst_fetch_pkg.sv | 20 ++
 rtl/inst_fetch_fifo.sv | 68 ++++++
 rtl/inst_fetch.sv | 124 ++++++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: widths, reset/NOP constants
// and the FIFO entry layout handed to decode.
package inst_fetch_pkg;

  localparam int          INST_ADDR_WIDTH  = 32;
  localparam int          INST_DATA_WIDTH  = 32;
  localparam int          ENTRY_WIDTH      = INST_ADDR_WIDTH + INST_DATA_WIDTH;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0000;

  typedef struct packed {
    logic [INST_ADDR_WIDTH-1:0] pc_plus4;
    logic [INST_DATA_WIDTH-1:0] inst;
  } fetch_entry_t;

  function automatic logic [INST_ADDR_WIDTH-1:0] align_word(input logic [INST_ADDR_WIDTH-1:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Synchronous instruction buffer between fetch and decode. Flush wins over push/pop;
// push and pop together while full is legal and leaves the count unchanged.
module inst_fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/inst_fetch.sv
// IF stage: owns the PC, issues credit-limited in-order fetches, tags each one with
// its pc+4, and buffers returned words for decode. Redirects flush and drop stale words.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] pc_plus4,
  output logic [31:0] inst
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [31:0]      tag_mem_q [FIFO_DEPTH];
  logic [31:0]      tag_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] tag_wr_q, tag_wr_d;
  logic [PTR_W-1:0] tag_rd_q, tag_rd_d;

  logic             credit_ok;
  logic             req_fire;
  logic             rsp_live;
  logic             fifo_push;
  logic             fifo_pop;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  fetch_entry_t     fifo_din;
  fetch_entry_t     fifo_head;

  // Credit counts every in-flight fetch (stale ones too) plus buffered words, so a
  // response always finds room. Reset gates the request so nothing issues while held.
  always_comb begin
    credit_ok      = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CNT_W+1)'(FIFO_DEPTH);
    imem_req_valid = rst && !redirect_valid && credit_ok;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_live       = imem_rsp_valid && !redirect_valid && (drop_cnt_q == '0);
    fifo_push      = rsp_live && (!fifo_full || fifo_pop);
    id_valid       = !fifo_empty && !redirect_valid;
    fifo_pop       = id_valid && id_ready;
    fifo_din       = '{pc_plus4: tag_mem_q[tag_rd_q], inst: imem_rsp_data};
    pc_plus4       = fifo_empty ? 32'h0    : fifo_head.pc_plus4;
    inst           = fifo_empty ? NOP_INST : fifo_head.inst;
    imem_req_addr  = pc_q;
  end

  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
    drop_cnt_d    = drop_cnt_q;
    tag_mem_d     = tag_mem_q;
    tag_wr_d      = tag_wr_q;
    tag_rd_d      = tag_rd_q;
    if (redirect_valid) begin
      // Everything still in flight becomes stale; drop_cnt_q is already a subset of it.
      pc_d       = align_word(redirect_pc);
      drop_cnt_d = outstanding_q - CNT_W'(imem_rsp_valid);
      tag_wr_d   = '0;
      tag_rd_d   = '0;
    end else begin
      if (req_fire) begin
        pc_d                = pc_q + 32'd4;
        tag_mem_d[tag_wr_q] = pc_q + 32'd4;
        tag_wr_d            = tag_wr_q + PTR_W'(1);
      end
      if (imem_rsp_valid && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CNT_W'(1);
      end
      if (rsp_live) begin
        tag_rd_d = tag_rd_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) tag_mem_q[i] <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      tag_wr_q      <= tag_wr_d;
      tag_rd_q      <= tag_rd_d;
      tag_mem_q     <= tag_mem_d;
    end
  end

  inst_fetch_fifo #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect_valid),
    .din   (fifo_din),
    .dout  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
